load_port: RTL
==============

// Module: load_port
// PURPOSE
//  Load-side counterpart of the store buffer. Queues issued loads and probes the store buffer CAM
//  (sb_ldaddr/sb_hit/sb_lddata). On a miss it reads dmem, holding memoccupy_ld so stores cannot
//  retire. Returns one result per load to writeback; squashes loads killed by branch mispredict.
// PARAMETERS
//  ADDR_LEN     16  load address width
//  DATA_LEN     32  load data width
//  SPECTAG_LEN  4   speculative tag width
//  DST_LEN      6   destination (rename) tag width
//  LDQ_DEPTH    4   load queue entries (power of 2, >=2)
//  MEM_LAT      2   dmem read latency in cycles (>=1)
// PORTS
//  clk          in   1            clock, rising edge
//  reset_n      in   1            asynchronous, active-low reset
//  ld_valid     in   1            load issue request
//  ld_ready     out  1            queue can accept (= not full)
//  ld_addr      in   ADDR_LEN     load address
//  ld_dst       in   DST_LEN      destination tag
//  ld_specbit   in   1            load is speculative
//  ld_spectag   in   SPECTAG_LEN  speculative tag
//  prsuccess    in   1            branch resolved correct
//  prmiss       in   1            branch mispredicted
//  prtag        in   SPECTAG_LEN  resolving branch tag
//  spectagfix   in   SPECTAG_LEN  tags killed on prmiss
//  sb_ldaddr    out  ADDR_LEN     store buffer probe address
//  sb_hit       in   1            store buffer hit (combinational)
//  sb_lddata    in   DATA_LEN     store buffer forwarded data
//  memoccupy_ld out  1            dmem port owned by load
//  dmem_raddr   out  ADDR_LEN     dmem read address
//  dmem_rdata   in   DATA_LEN     dmem read data, MEM_LAT cycles after address
//  res_valid    out  1            result pulse, no back-pressure
//  res_data     out  DATA_LEN     load data
//  res_dst      out  DST_LEN      load destination tag
// BEHAVIOUR
//  - Reset (async, reset_n=0): queue empty, FSM IDLE, ld_ready=1, memoccupy_ld=0, res_valid=0,
//    res_data=0, res_dst=0, sb_ldaddr=0, dmem_raddr=0, all valid/specbits cleared.
//  - Queue: FIFO, head/tail ptrs wrap mod LDQ_DEPTH; full = count==LDQ_DEPTH. Accept iff
//    ld_valid&ld_ready. No same-cycle pass-through when full.
//  - FSM: IDLE -> PROBE when head valid; head is popped on entering PROBE.
//    PROBE: sb_ldaddr=addr; sb_hit=1 -> capture sb_lddata, go IDLE; res_valid next cycle.
//    sb_hit=0 -> MEM, cnt=MEM_LAT-1. MEM: memoccupy_ld=1, dmem_raddr=addr held;
//    cnt decrements; at cnt==0 capture dmem_rdata, go IDLE, res_valid next cycle.
//  - Latency (no bypass, empty queue): hit = accept+2 cycles; miss = accept+2+MEM_LAT.
//  - memoccupy_ld is 1 only in MEM; it is registered so storebuf stretire never races a load read.
//  - prsuccess: clear specbit of every entry (and in-flight op) with spectag==prtag.
//  - prmiss: invalidate entries with specbit && (spectag&spectagfix)!=0; compact not required
//    (invalid entries are skipped at head, one per cycle). In-flight op killed in PROBE -> IDLE,
//    no result; killed in MEM -> finishes MEM_LAT cycles with memoccupy_ld held, result suppressed.
//  - Load accepted in the prmiss cycle is not killed. In the prsuccess cycle, its specbit is cleared
//    if ld_spectag==prtag.
//  - prmiss and prsuccess together: prmiss wins, specbits not updated.
//  - res_valid is a 1-cycle pulse; res_data/res_dst hold until the next result.
// CONFIGURATION
//  LOAD_PORT_BYPASS_EN defined: when FSM IDLE and queue empty, an accepted load probes
//    in its accept cycle (skips the queue); hit latency accept+1, miss accept+1+MEM_LAT.
//  Undefined: every load passes through the queue; latencies as above.
// TESTING
//  1 reset_n low mid-MEM -> memoccupy_ld=0, res_valid=0, ld_ready=1 immediately (async).
//  2 load addr 0x0040 dst 5, sb_hit=1 data 0xDEADBEEF -> res_valid at accept+2, data 0xDEADBEEF,
//    dst 5, memoccupy_ld never 1.
//  3 load 0x0080 miss, dmem[0x0080]=0x12345678, MEM_LAT=2 -> memoccupy_ld high 2 cycles,
//    res 0x12345678 at accept+4.
//  4 issue 5 loads back-to-back, no drain -> ld_ready=0 after 4th; 5th accepted after first pop;
//    results in issue order.
//  5 two loads spectag 4'b0010 specbit=1, prmiss with spectagfix 4'b0010 during MEM of first ->
//    no results for either, memoccupy_ld still 2 cycles.
//  6 LOAD_PORT_BYPASS_EN, idle, hit load -> res_valid at accept+1.

Source files
------------

// File: rtl/load_port.sv
// Load port: queues issued loads, probes the store buffer, falls back to dmem on a miss.
// Define LOAD_PORT_BYPASS_EN to let a load arriving at an idle, empty port skip the queue.
module load_port #(
  parameter int unsigned AddrLen    = 16,
  parameter int unsigned DataLen    = 32,
  parameter int unsigned SpectagLen = 4,
  parameter int unsigned DstLen     = 6,
  parameter int unsigned LdqDepth   = 4,
  parameter int unsigned MemLat     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [AddrLen-1:0]    ld_addr_i,
  input  logic [DstLen-1:0]     ld_dst_i,
  input  logic                  ld_specbit_i,
  input  logic [SpectagLen-1:0] ld_spectag_i,
  input  logic                  prsuccess_i,
  input  logic                  prmiss_i,
  input  logic [SpectagLen-1:0] prtag_i,
  input  logic [SpectagLen-1:0] spectagfix_i,
  output logic [AddrLen-1:0]    sb_ldaddr_o,
  input  logic                  sb_hit_i,
  input  logic [DataLen-1:0]    sb_lddata_i,
  output logic                  memoccupy_ld_o,
  output logic [AddrLen-1:0]    dmem_raddr_o,
  input  logic [DataLen-1:0]    dmem_rdata_i,
  output logic                  res_valid_o,
  output logic [DataLen-1:0]    res_data_o,
  output logic [DstLen-1:0]     res_dst_o
);

  localparam int unsigned PtrW   = $clog2(LdqDepth);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = (MemLat > 1) ? $clog2(MemLat) : 1;
  localparam logic [CountW-1:0] Full = CountW'(LdqDepth);

  typedef enum logic [1:0] {StIdle, StProbe, StMem} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CountW-1:0]     count_q, count_d;
  logic                  e_vld_q  [LdqDepth];
  logic                  e_vld_d  [LdqDepth];
  logic                  e_spec_q [LdqDepth];
  logic                  e_spec_d [LdqDepth];
  logic [SpectagLen-1:0] e_tag_q  [LdqDepth];
  logic [SpectagLen-1:0] e_tag_d  [LdqDepth];
  logic [AddrLen-1:0]    e_addr_q [LdqDepth];
  logic [AddrLen-1:0]    e_addr_d [LdqDepth];
  logic [DstLen-1:0]     e_dst_q  [LdqDepth];
  logic [DstLen-1:0]     e_dst_d  [LdqDepth];

  logic [AddrLen-1:0]    cur_addr_q, cur_addr_d;
  logic [DstLen-1:0]     cur_dst_q, cur_dst_d;
  logic                  cur_spec_q, cur_spec_d;
  logic [SpectagLen-1:0] cur_tag_q, cur_tag_d;
  logic                  cur_kill_q, cur_kill_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [AddrLen-1:0]    raddr_q, raddr_d;
  logic                  memocc_q, memocc_d;
  logic                  res_valid_q, res_valid_d;
  logic [DataLen-1:0]    res_data_q, res_data_d;
  logic [DstLen-1:0]     res_dst_q, res_dst_d;

  logic push, pop, bypass;

  // prmiss takes priority: a cycle with both never clears specbits.
  function automatic logic is_killed(logic spec, logic [SpectagLen-1:0] tag);
    return prmiss_i && spec && (|(tag & spectagfix_i));
  endfunction

  function automatic logic is_resolved(logic [SpectagLen-1:0] tag);
    return prsuccess_i && !prmiss_i && (tag == prtag_i);
  endfunction

  assign ld_ready_o     = (count_q != Full);
  assign push           = ld_valid_i && ld_ready_o;
  assign sb_ldaddr_o    = cur_addr_q;
  assign dmem_raddr_o   = raddr_q;
  assign memoccupy_ld_o = memocc_q;
  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign res_dst_o      = res_dst_q;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cur_addr_d  = cur_addr_q;
    cur_dst_d   = cur_dst_q;
    cur_spec_d  = cur_spec_q;
    cur_tag_d   = cur_tag_q;
    cur_kill_d  = cur_kill_q;
    cnt_d       = cnt_q;
    raddr_d     = raddr_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_dst_d   = res_dst_q;
    e_vld_d     = e_vld_q;
    e_spec_d    = e_spec_q;
    e_tag_d     = e_tag_q;
    e_addr_d    = e_addr_q;
    e_dst_d     = e_dst_q;
    pop         = 1'b0;
    bypass      = 1'b0;
`ifdef LOAD_PORT_BYPASS_EN
    bypass = push && (state_q == StIdle) && (count_q == '0);
`endif

    for (int i = 0; i < int'(LdqDepth); i++) begin
      if (is_killed(e_spec_q[i], e_tag_q[i])) begin
        e_vld_d[i] = 1'b0;
      end else if (is_resolved(e_tag_q[i])) begin
        e_spec_d[i] = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bypass) begin
          // Accepted load goes straight into PROBE from its accept edge.
          cur_addr_d = ld_addr_i;
          cur_dst_d  = ld_dst_i;
          cur_spec_d = ld_specbit_i && !is_resolved(ld_spectag_i);
          cur_tag_d  = ld_spectag_i;
          state_d    = StProbe;
        end else if (count_q != '0) begin
          // Killed entries are dropped here, one per cycle.
          pop = 1'b1;
          if (e_vld_q[head_q] && !is_killed(e_spec_q[head_q], e_tag_q[head_q])) begin
            cur_addr_d = e_addr_q[head_q];
            cur_dst_d  = e_dst_q[head_q];
            cur_spec_d = e_spec_q[head_q] && !is_resolved(e_tag_q[head_q]);
            cur_tag_d  = e_tag_q[head_q];
            state_d    = StProbe;
          end
        end
      end
      StProbe: begin
        cur_spec_d = cur_spec_q && !is_resolved(cur_tag_q);
        if (is_killed(cur_spec_q, cur_tag_q)) begin
          state_d = StIdle;
        end else if (sb_hit_i) begin
          state_d     = StIdle;
          res_valid_d = 1'b1;
          res_data_d  = sb_lddata_i;
          res_dst_d   = cur_dst_q;
        end else begin
          state_d    = StMem;
          cnt_d      = CntW'(MemLat - 1);
          raddr_d    = cur_addr_q;
          cur_kill_d = 1'b0;
        end
      end
      StMem: begin
        // A kill here only suppresses the result; the dmem read still runs to completion.
        cur_spec_d = cur_spec_q && !is_resolved(cur_tag_q);
        if (is_killed(cur_spec_q, cur_tag_q)) cur_kill_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (!cur_kill_d) begin
            res_valid_d = 1'b1;
            res_data_d  = dmem_rdata_i;
            res_dst_d   = cur_dst_q;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      e_vld_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push && !bypass) begin
      e_vld_d[tail_q]  = 1'b1;
      e_spec_d[tail_q] = ld_specbit_i && !is_resolved(ld_spectag_i);
      e_tag_d[tail_q]  = ld_spectag_i;
      e_addr_d[tail_q] = ld_addr_i;
      e_dst_d[tail_q]  = ld_dst_i;
      tail_d           = tail_q + PtrW'(1);
    end
    count_d  = count_q + CountW'(push && !bypass) - CountW'(pop);
    memocc_d = (state_d == StMem);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cur_addr_q  <= '0;
      cur_dst_q   <= '0;
      cur_spec_q  <= 1'b0;
      cur_tag_q   <= '0;
      cur_kill_q  <= 1'b0;
      cnt_q       <= '0;
      raddr_q     <= '0;
      memocc_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_dst_q   <= '0;
      for (int i = 0; i < int'(LdqDepth); i++) begin
        e_vld_q[i]  <= 1'b0;
        e_spec_q[i] <= 1'b0;
        e_tag_q[i]  <= '0;
        e_addr_q[i] <= '0;
        e_dst_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cur_addr_q  <= cur_addr_d;
      cur_dst_q   <= cur_dst_d;
      cur_spec_q  <= cur_spec_d;
      cur_tag_q   <= cur_tag_d;
      cur_kill_q  <= cur_kill_d;
      cnt_q       <= cnt_d;
      raddr_q     <= raddr_d;
      memocc_q    <= memocc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_dst_q   <= res_dst_d;
      for (int i = 0; i < int'(LdqDepth); i++) begin
        e_vld_q[i]  <= e_vld_d[i];
        e_spec_q[i] <= e_spec_d[i];
        e_tag_q[i]  <= e_tag_d[i];
        e_addr_q[i] <= e_addr_d[i];
        e_dst_q[i]  <= e_dst_d[i];
      end
    end
  end

endmodule
